// File: rtl/temp_scan_ctrl.sv
// temp_scan_ctrl: steps the shared temperature readout mux through the enabled
// sensors, lets the selected sensor settle, runs one conversion per sensor and
// writes each {dac, ticks} result (or all-ones fill on timeout) to a result bank.
module temp_scan_ctrl #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        one_shot_i,
    input  logic [3:0]  sensor_mask_i,
    input  logic        conv_done_i,
    input  logic [11:0] temp_ticks_i,
    input  logic [5:0]  temp_dac_i,
    output logic [1:0]  temp_sel_o,
    output logic        conv_start_o,
    output logic        result_wr_o,
    output logic [1:0]  result_adr_o,
    output logic [17:0] result_dat_o,
    output logic        busy_o,
    output logic        scan_done_o,
    output logic [3:0]  timeout_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        STORE,
        NEXT
    } state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] cnt_q, cnt_d;
    logic [17:0] data_q, data_d;
    logic [1:0]  adr_q, adr_d;
    logic [3:0]  timeout_q, timeout_d;
    logic [2:0]  next_hit;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = i[1:0];
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above cur.
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && m[i]) r = {1'b1, i[1:0]};
        end
        return r;
    endfunction

    assign next_hit     = next_above(mask_q, idx_q);
    assign temp_sel_o   = idx_q;
    assign result_adr_o = adr_q;
    assign result_dat_o = data_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = (state_q != IDLE);

    // State, index, counter and result registers; reset aborts any pass in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            mask_q    <= 4'd0;
            cnt_q     <= 16'd0;
            data_q    <= 18'd0;
            adr_q     <= 2'd0;
            timeout_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            adr_q     <= adr_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic and the single-cycle strobes of the scan sequence.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        adr_d        = adr_q;
        timeout_d    = timeout_q;
        conv_start_o = 1'b0;
        result_wr_o  = 1'b0;
        scan_done_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if ((en_i || one_shot_i) && (sensor_mask_i != 4'd0)) begin
                    mask_d    = sensor_mask_i;
                    timeout_d = 4'd0;
                    idx_d     = lowest_bit(sensor_mask_i);
                    cnt_d     = 16'd0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            START: begin
                conv_start_o = 1'b1;
                cnt_d        = 16'd0;
                state_d      = WAIT;
            end
            WAIT: begin
                if (conv_done_i) begin
                    data_d  = {temp_dac_i, temp_ticks_i};
                    adr_d   = idx_q;
                    state_d = STORE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    timeout_d[idx_q] = 1'b1;
                    data_d           = 18'h3FFFF;
                    adr_d            = idx_q;
                    state_d          = STORE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STORE: begin
                result_wr_o = 1'b1;
                state_d     = NEXT;
            end
            NEXT: begin
                cnt_d = 16'd0;
                if (next_hit[2]) begin
                    idx_d   = next_hit[1:0];
                    state_d = SETTLE;
                end else begin
                    scan_done_o = 1'b1;
                    if (en_i) begin
                        mask_d    = sensor_mask_i;
                        timeout_d = 4'd0;
                        if (sensor_mask_i != 4'd0) begin
                            idx_d   = lowest_bit(sensor_mask_i);
                            state_d = SETTLE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
